// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, instruction size,
// skid FIFO geometry and a pointer-increment helper for the FIFO.
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned FIFO_DEPTH  = 2;
  localparam int unsigned FIFO_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FIFO_CNT_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Circular pointer increment that also works for non-power-of-two depths.
  function automatic logic [FIFO_PTR_W-1:0] fifo_ptr_inc(input logic [FIFO_PTR_W-1:0] p);
    return (p == FIFO_PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + FIFO_PTR_W'(1);
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Small {pc, instr} FIFO between the memory response and the decode port.
// Flush has priority over push/pop; the head entry is visible combinationally.
module fetch_skid_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic [XLEN-1:0]       push_pc,
  input  logic [XLEN-1:0]       push_instr,
  input  logic                  pop,
  output logic                  valid,
  output logic [XLEN-1:0]       head_pc,
  output logic [XLEN-1:0]       head_instr,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [XLEN-1:0]       pc_mem_q    [FIFO_DEPTH];
  logic [XLEN-1:0]       instr_mem_q [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_q;
  logic [FIFO_PTR_W-1:0] rd_ptr_q;
  logic [FIFO_CNT_W-1:0] count_q;

  // Storage, pointers and occupancy; storage is cleared so outputs read 0 after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        pc_mem_q[wr_ptr_q]    <= push_pc;
        instr_mem_q[wr_ptr_q] <= push_instr;
        wr_ptr_q              <= fifo_ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= fifo_ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + FIFO_CNT_W'(push) - FIFO_CNT_W'(pop);
    end
  end

  // Head-of-queue view for the decode port.
  always_comb begin
    valid      = (count_q != '0);
    head_pc    = pc_mem_q[rd_ptr_q];
    head_instr = instr_mem_q[rd_ptr_q];
    count      = count_q;
  end

  // The upstream credit rule must never push a full FIFO unless the head leaves too.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      assert (!(push && !pop && (count_q == FIFO_CNT_W'(FIFO_DEPTH))))
        else $error("fetch_skid_fifo: push while full");
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues 1-cycle-latency reads to the
// instruction memory, buffers responses in a 2-entry skid FIFO and handles
// redirects by flushing the queue and dropping the stale in-flight response.
// Optional feature macro: FETCH_FAULT_EN (address range/alignment check + HALT).
module imem_fetch_ctrl
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [$clog2(DEPTH)-1:0] imem_addr,
  input  logic [XLEN-1:0]          imem_rdata,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     if_valid,
  input  logic                     if_ready,
  output logic [XLEN-1:0]          if_pc,
  output logic [XLEN-1:0]          if_instr,
  output logic                     if_fault
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = FIFO_CNT_W + 1;

  fetch_state_e          state_q, state_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic                  inflight_q, inflight_d;
  logic [XLEN-1:0]       inflight_pc_q, inflight_pc_d;
  logic                  req;
  logic [XLEN-1:0]       issue_pc;
  logic                  pop;
  logic                  push;
  logic                  flush;
  logic                  credit_ok;
  logic [OW-1:0]         occupancy;
  logic                  fifo_valid;
  logic [FIFO_CNT_W-1:0] fifo_count;

`ifdef FETCH_FAULT_EN
  logic fault_q, fault_d;

  function automatic logic addr_fault(input logic [XLEN-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= XLEN'(DEPTH));
  endfunction
`endif

  assign pop = fifo_valid & if_ready;

  // Entries the FIFO will hold once everything already requested has landed.
  assign occupancy = {1'b0, fifo_count} + OW'(inflight_q) - OW'(pop);
  assign credit_ok = (occupancy < OW'(FIFO_DEPTH));

  // Next-state, PC and request decode; a redirect overrides every state.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req      = 1'b0;
    issue_pc = pc_q;
    flush    = 1'b0;
    // A response arriving in a redirect cycle belongs to the old stream: drop it.
    push     = inflight_q & ~redirect_valid;
`ifdef FETCH_FAULT_EN
    fault_d  = fault_q;
`endif
    if (redirect_valid) begin
      flush    = 1'b1;
      state_d  = FETCH;
      issue_pc = redirect_pc;
`ifdef FETCH_FAULT_EN
      fault_d  = 1'b0;
      if (addr_fault(redirect_pc)) begin
        state_d = HALT;
        fault_d = 1'b1;
        pc_d    = redirect_pc;
      end else begin
        req  = 1'b1;
        pc_d = redirect_pc + XLEN'(INSTR_BYTES);
      end
`else
      req  = 1'b1;
      pc_d = redirect_pc + XLEN'(INSTR_BYTES);
`endif
    end else begin
      unique case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
`ifdef FETCH_FAULT_EN
          if (addr_fault(pc_q)) begin
            state_d = HALT;
            fault_d = 1'b1;
          end else if (credit_ok) begin
            req  = 1'b1;
            pc_d = pc_q + XLEN'(INSTR_BYTES);
          end
`else
          if (credit_ok) begin
            req  = 1'b1;
            pc_d = pc_q + XLEN'(INSTR_BYTES);
          end
`endif
        end
        HALT: state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
    inflight_d    = req;
    inflight_pc_d = issue_pc;
  end

  // FSM, fetch PC and in-flight tracking; reset discards any outstanding read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
`ifdef FETCH_FAULT_EN
      fault_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
`ifdef FETCH_FAULT_EN
      fault_q       <= fault_d;
`endif
    end
  end

  // Memory request outputs; out-of-range bits are simply truncated when unchecked.
  always_comb begin
    imem_req  = req;
    imem_addr = issue_pc[AW+1:2];
  end

`ifdef FETCH_FAULT_EN
  assign if_fault = fault_q;
`else
  assign if_fault = 1'b0;
`endif

  fetch_skid_fifo #(
    .XLEN (XLEN)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push       (push),
    .push_pc    (inflight_pc_q),
    .push_instr (imem_rdata),
    .pop        (pop),
    .valid      (fifo_valid),
    .head_pc    (if_pc),
    .head_instr (if_instr),
    .count      (fifo_count)
  );

  assign if_valid = fifo_valid;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl. Memory model returns word index k as data.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_fault;

  int n_pass = 0;
  int n_total = 0;

  imem_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_fault       (if_fault)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: word k holds k; garbage when not requested.
  always @(posedge clk) imem_rdata <= imem_req ? {26'h0, imem_addr} : 32'hDEAD_BEEF;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // Leaves the caller at the negedge where reset drops (cycle 0, state IDLE).
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; if_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_total++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req);
    else n_pass++;
    n_total++; if (imem_addr !== 6'd0) $display("FAIL reset_addr: got %0d want 0", imem_addr);
    else n_pass++;
    n_total++;
    if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0 || if_fault !== 1'b0)
      $display("FAIL reset_if: got v=%b pc=%h i=%h f=%b want all 0",
               if_valid, if_pc, if_instr, if_fault);
    else n_pass++;
    do_reset();
    #1;
    n_total++; if (imem_req !== 1'b0) $display("FAIL idle_req: got %b want 0", imem_req);
    else n_pass++;
  endtask

  task automatic test_stream();
    do_reset();
    if_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #1;
      n_total++;
      if (imem_req !== 1'b1 || imem_addr !== 6'(k - 1))
        $display("FAIL stream_req c%0d: got req=%b addr=%0d want 1/%0d",
                 k, imem_req, imem_addr, k - 1);
      else n_pass++;
      n_total++;
      if (k < 3) begin
        if (if_valid !== 1'b0) $display("FAIL stream_lat c%0d: got v=%b want 0", k, if_valid);
        else n_pass++;
      end else begin
        if (if_valid !== 1'b1 || if_pc !== 32'(4 * (k - 3)) || if_instr !== 32'(k - 3))
          $display("FAIL stream_data c%0d: got v=%b pc=%h i=%h want 1/%h/%h",
                   k, if_valid, if_pc, if_instr, 4 * (k - 3), k - 3);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    if_ready = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    if_ready = 1'b0;
    #1;
    for (int k = 3; k <= 8; k++) begin
      if (k > 3) begin @(negedge clk); #1; end
      n_total++;
      if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h0)
        $display("FAIL bp_hold c%0d: got req=%b v=%b pc=%h want 0/1/0",
                 k, imem_req, if_valid, if_pc);
      else n_pass++;
    end
    @(negedge clk);
    if_ready = 1'b1;
    #1;
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 6'd2)
      $display("FAIL bp_resume_req: got req=%b addr=%0d want 1/2", imem_req, imem_addr);
    else n_pass++;
    for (int k = 9; k <= 13; k++) begin
      if (k > 9) begin @(negedge clk); #1; end
      n_total++;
      if (if_valid !== 1'b1 || if_pc !== 32'(4 * (k - 9)))
        $display("FAIL bp_drain c%0d: got v=%b pc=%h want 1/%h", k, if_valid, if_pc, 4 * (k - 9));
      else n_pass++;
    end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (2) @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 6'd16)
      $display("FAIL redir_req: got req=%b addr=%0d want 1/16", imem_req, imem_addr);
    else n_pass++;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_total++; if (if_valid !== 1'b0) $display("FAIL redir_flush: got v=%b want 0", if_valid);
    else n_pass++;
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 6'd17)
      $display("FAIL redir_next_req: got req=%b addr=%0d want 1/17", imem_req, imem_addr);
    else n_pass++;
    @(negedge clk);
    if_ready = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      n_total++;
      if (if_valid !== 1'b1 || if_pc !== 32'(32'h40 + 4 * k) || if_instr !== 32'(16 + k))
        $display("FAIL redir_data %0d: got v=%b pc=%h i=%h want 1/%h/%h",
                 k, if_valid, if_pc, if_instr, 32'h40 + 4 * k, 16 + k);
      else n_pass++;
    end
  endtask

  task automatic test_redirect_pop();
    int accepted;
    accepted = 0;
    do_reset();
    if_ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      redirect_valid = (k == 5);
      redirect_pc    = 32'h80;
      #1;
      if (if_valid && if_ready && if_pc == 32'h8) accepted++;
      if (k == 5) begin
        n_total++;
        if (if_valid !== 1'b1 || if_pc !== 32'h8 || imem_req !== 1'b1 || imem_addr !== 6'd32)
          $display("FAIL rpop_same: got v=%b pc=%h req=%b addr=%0d want 1/8/1/32",
                   if_valid, if_pc, imem_req, imem_addr);
        else n_pass++;
      end else if (k == 6) begin
        n_total++; if (if_valid !== 1'b0) $display("FAIL rpop_gap: got v=%b want 0", if_valid);
        else n_pass++;
      end else if (k == 7) begin
        n_total++;
        if (if_valid !== 1'b1 || if_pc !== 32'h80 || if_instr !== 32'd32)
          $display("FAIL rpop_target: got v=%b pc=%h i=%h want 1/80/20",
                   if_valid, if_pc, if_instr);
        else n_pass++;
      end
    end
    redirect_valid = 1'b0;
    n_total++; if (accepted != 1) $display("FAIL rpop_once: got %0d want 1", accepted);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    if_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 5) if_ready = 1'b0;
    end
    @(negedge clk); #1;
    n_total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== 32'd2)
      $display("FAIL mid_pre: got v=%b pc=%h i=%h want 1/8/2", if_valid, if_pc, if_instr);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_total++;
    if (imem_req !== 1'b0 || imem_addr !== 6'd0 || if_valid !== 1'b0 ||
        if_pc !== 32'h0 || if_instr !== 32'h0 || if_fault !== 1'b0)
      $display("FAIL mid_async: got req=%b a=%0d v=%b pc=%h i=%h f=%b want all 0",
               imem_req, imem_addr, if_valid, if_pc, if_instr, if_fault);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0; if_ready = 1'b1;
    #1;
    n_total++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0)
      $display("FAIL mid_idle: got req=%b v=%b want 0/0", imem_req, if_valid);
    else n_pass++;
    @(negedge clk); #1;
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 6'd0 || if_valid !== 1'b0)
      $display("FAIL mid_restart: got req=%b a=%0d v=%b want 1/0/0", imem_req, imem_addr, if_valid);
    else n_pass++;
    @(negedge clk); #1;
    n_total++; if (if_valid !== 1'b0) $display("FAIL mid_stale: got v=%b want 0", if_valid);
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      n_total++;
      if (if_valid !== 1'b1 || if_pc !== 32'(4 * k) || if_instr !== 32'(k))
        $display("FAIL mid_data %0d: got v=%b pc=%h i=%h want 1/%h/%h",
                 k, if_valid, if_pc, if_instr, 4 * k, k);
      else n_pass++;
    end
  endtask

  task automatic test_fault();
    do_reset();
`ifdef FETCH_FAULT_EN
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    #1;
    n_total++; if (imem_req !== 1'b0) $display("FAIL flt_mis_req: got %b want 0", imem_req);
    else n_pass++;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      n_total++;
      if (if_fault !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0)
        $display("FAIL flt_mis_hold %0d: got f=%b req=%b v=%b want 1/0/0",
                 k, if_fault, imem_req, if_valid);
      else n_pass++;
    end
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    n_total++; if (imem_req !== 1'b0) $display("FAIL flt_rng_req: got %b want 0", imem_req);
    else n_pass++;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_total++;
    if (if_fault !== 1'b1 || imem_req !== 1'b0)
      $display("FAIL flt_rng_hold: got f=%b req=%b want 1/0", if_fault, imem_req);
    else n_pass++;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    #1;
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 6'd0)
      $display("FAIL flt_clr_req: got req=%b a=%0d want 1/0", imem_req, imem_addr);
    else n_pass++;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_total++;
    if (if_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 6'd1)
      $display("FAIL flt_clr: got f=%b req=%b a=%0d want 0/1/1", if_fault, imem_req, imem_addr);
    else n_pass++;
    @(negedge clk); #1;
    n_total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0)
      $display("FAIL flt_resume: got v=%b pc=%h want 1/0", if_valid, if_pc);
    else n_pass++;
`else
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 6'd0)
      $display("FAIL wrap_req: got req=%b a=%0d want 1/0", imem_req, imem_addr);
    else n_pass++;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_total++; if (if_fault !== 1'b0) $display("FAIL wrap_fault: got %b want 0", if_fault);
    else n_pass++;
    @(negedge clk); #1;
    n_total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== 32'h0)
      $display("FAIL wrap_data: got v=%b pc=%h i=%h want 1/100/0", if_valid, if_pc, if_instr);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_reset_mid();
    test_fault();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
